// File: rtl/delay_meter_pkg.sv
// Shared types for the delay edge meter: FSM state encoding, default counter width
// and the packed result record.
package delay_meter_pkg;

    localparam int DEFAULT_CNT_W = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_e;

    // cnt is sized by the package default; the top keeps CNT_W at this value.
    typedef struct packed {
        logic                     timeout;
        logic [DEFAULT_CNT_W-1:0] cnt;
    } result_t;

endpackage

// File: rtl/delay_edge_meter_edge_detect.sv
// Per-bit input register plus rising-edge pulse. The register clears on reset,
// so a line that is already high coming out of reset shows up as an edge.
module edge_detect #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] rise_o
);

    logic [W-1:0] d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q <= '0;
        end else begin
            d_q <= d_i;
        end
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/delay_edge_meter.sv
// Measures the cycle distance between a ref rising edge and the matching delayed
// rising edge on one channel. Optional min/max statistics: DELAY_METER_MINMAX_EN.
module delay_edge_meter
    import delay_meter_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int CH_W    = 4,
    parameter int CNT_W   = DEFAULT_CNT_W,
    parameter int TIMEOUT = 2047
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CH_W-1:0]  ch_sel,
    input  logic [WIDTH-1:0] ref_in,
    input  logic [WIDTH-1:0] dly_in,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_cnt,
    output logic             res_timeout,
`ifdef DELAY_METER_MINMAX_EN
    input  logic             stats_clr,
    output logic [CNT_W-1:0] min_cnt,
    output logic [CNT_W-1:0] max_cnt,
`endif
    output logic [1:0]       dbg_state
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_ARM   = ARM;
    localparam logic [1:0] ST_COUNT = COUNT;
    localparam logic [1:0] ST_DONE  = DONE;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    result_t          res_q, res_d;

    logic [WIDTH-1:0] ref_rise, dly_rise;
    logic             ref_e, dly_e;
    logic [CNT_W-1:0] cnt_inc;
    logic             handshake;

    edge_detect #(.W(WIDTH)) u_ref_edge (
        .clk    (clk),
        .rst    (rst),
        .d_i    (ref_in),
        .rise_o (ref_rise)
    );

    edge_detect #(.W(WIDTH)) u_dly_edge (
        .clk    (clk),
        .rst    (rst),
        .d_i    (dly_in),
        .rise_o (dly_rise)
    );

    assign ref_e   = ref_rise[ch_q];
    assign dly_e   = dly_rise[ch_q];
    assign cnt_inc = cnt_q + CNT_W'(1);

    // Result handshake: res_valid is high for the whole DONE state and res_cnt /
    // res_timeout are frozen there; a transfer happens on a clock edge where
    // res_valid & res_ready, after which the FSM is back in IDLE.
    assign handshake = res_valid & res_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        res_d   = res_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ch_d  = ch_sel;
                    cnt_d = '0;
                    if (int'(ch_sel) >= WIDTH) begin
                        state_d = ST_DONE;
                        res_d   = '{timeout: 1'b1, cnt: '0};
                    end else begin
                        state_d = ST_ARM;
                    end
                end
            end
            ST_ARM: begin
                // A dly edge before any ref edge belongs to an older event and is ignored.
                if (ref_e && dly_e) begin
                    state_d = ST_DONE;
                    res_d   = '{timeout: 1'b0, cnt: '0};
                end else if (ref_e) begin
                    state_d = ST_COUNT;
                    cnt_d   = CNT_W'(1);
                end else if (cnt_inc == TIMEOUT_C) begin
                    state_d = ST_DONE;
                    res_d   = '{timeout: 1'b1, cnt: '0};
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_COUNT: begin
                if (dly_e) begin
                    state_d = ST_DONE;
                    res_d   = '{timeout: 1'b0, cnt: cnt_q};
                end else if (cnt_inc == TIMEOUT_C) begin
                    state_d = ST_DONE;
                    res_d   = '{timeout: 1'b1, cnt: TIMEOUT_C};
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ch_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            res_q   <= res_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign res_valid   = (state_q == ST_DONE);
    assign res_cnt     = res_q.cnt;
    assign res_timeout = res_q.timeout;
    assign dbg_state   = state_q;

`ifdef DELAY_METER_MINMAX_EN
    logic [CNT_W-1:0] min_q, min_d;
    logic [CNT_W-1:0] max_q, max_d;

    // A clear in the same cycle as a handshake discards that result.
    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (stats_clr) begin
            min_d = '1;
            max_d = '0;
        end else if (handshake && !res_q.timeout) begin
            if (res_q.cnt < min_q) min_d = res_q.cnt;
            if (res_q.cnt > max_q) max_d = res_q.cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_q <= '1;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign min_cnt = min_q;
    assign max_cnt = max_q;
`else
    logic unused_handshake;
    assign unused_handshake = handshake;
`endif

endmodule
